// File: rtl/pcie_rx_link.sv
// Receive side of the byte-wide link: frames header/payload/checksum packets, verifies the XOR
// checksum and commits whole good packets into a first-word-fall-through Rx FIFO.
module pcie_rx_link #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [3:0]    CONTROL,
    input  logic [7:0]    DATA,
    input  logic          VALID_IN,
    input  logic          RD,
    output logic [7:0]    Rx_Buffer,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT,
    output logic          PKT_OK,
    output logic          ERR,
    output logic [1:0]    ERR_CODE,
    output logic [1:0]    fsm_state
);

    // Handshake: a link byte transfers on a rising edge when VALID_IN && CONTROL[0]; there is
    // no ready, packets that cannot be held are consumed and dropped. Reads pop on RD && !EMPTY.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state;
    state_t        state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_tmp;
    logic [AW:0]   count;
    logic [AW:0]   tent;
    logic [3:0]    rem;
    logic [3:0]    len_q;
    logic [7:0]    acc;
    logic          pkt_ok_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic          accept;
    logic          flush;
    logic          pop;
    logic          fits;
    logic [AW:0]   hdr_len;
    logic [AW:0]   commit_len;
    logic          take_hdr;
    logic          wr_en;
    logic          commit;
    logic          abort;
    logic          drop_byte;
    logic          drop_done;
    logic          unused_ctrl;

    assign unused_ctrl = ^CONTROL[3:2];

    assign accept     = VALID_IN && CONTROL[0];
    assign flush      = CONTROL[1];
    assign EMPTY      = (count == '0);
    assign pop        = RD && !EMPTY && !flush;
    assign hdr_len    = (AW+1)'(DATA[3:0]);
    // Space is judged against committed data only; tentative bytes are always zero in IDLE.
    assign fits       = (hdr_len <= (DEPTH_V - count));
    assign commit_len = commit ? (AW+1)'(len_q) : '0;

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (DATA[3:0] == 4'd0) begin
                        state_nxt = CHECK;
                    end else if (fits) begin
                        state_nxt = PAYLOAD;
                    end else begin
                        state_nxt = DROP;
                    end
                end
                PAYLOAD: begin
                    if (rem == 4'd1) begin
                        state_nxt = CHECK;
                    end
                end
                CHECK: state_nxt = IDLE;
                DROP: begin
                    if (rem == 4'd0) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: per-cycle datapath strobes
    always_comb begin
        take_hdr  = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        drop_byte = 1'b0;
        drop_done = 1'b0;
        if (accept && !flush) begin
            unique case (state)
                IDLE:    take_hdr = 1'b1;
                PAYLOAD: wr_en    = 1'b1;
                CHECK: begin
                    if (DATA == acc) begin
                        commit = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
                DROP: begin
                    if (rem == 4'd0) begin
                        drop_done = 1'b1;
                    end else begin
                        drop_byte = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_tmp] <= DATA;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            wr_tmp     <= '0;
            count      <= '0;
            tent       <= '0;
            rem        <= '0;
            len_q      <= '0;
            acc        <= '0;
            pkt_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wr_tmp   <= '0;
            count    <= '0;
            tent     <= '0;
            rem      <= '0;
            len_q    <= '0;
            acc      <= '0;
            pkt_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pkt_ok_q <= commit;
            err_q    <= abort || drop_done;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + commit_len - (pop ? CNT_ONE : '0);
            if (take_hdr) begin
                len_q <= DATA[3:0];
                rem   <= DATA[3:0];
                acc   <= DATA;
            end
            if (wr_en) begin
                wr_tmp <= wr_tmp + PTR_ONE;
                tent   <= tent + CNT_ONE;
                rem    <= rem - 4'd1;
                acc    <= acc ^ DATA;
            end
            if (drop_byte) begin
                rem <= rem - 4'd1;
            end
            if (commit) begin
                wr_ptr <= wr_tmp;
                tent   <= '0;
            end
            if (abort) begin
                wr_tmp     <= wr_ptr;
                tent       <= '0;
                err_code_q <= 2'b01;
            end
            if (drop_done) begin
                err_code_q <= 2'b10;
            end
        end
    end

    assign Rx_Buffer = mem[rd_ptr];
    assign COUNT     = count;
    assign FULL      = ((count + tent) == DEPTH_V);
    assign PKT_OK    = pkt_ok_q;
    assign ERR       = err_q;
    assign ERR_CODE  = err_code_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_pcie_rx_link.sv
// Directed bench for pcie_rx_link: framing, checksum, overflow drop, wrap with gaps, reset/flush
// recovery and zero-length packets, checked against an expected-byte queue.
module tb_pcie_rx_link;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    logic          CLK;
    logic          reset;
    logic [3:0]    CONTROL;
    logic [7:0]    DATA;
    logic          VALID_IN;
    logic          RD;
    logic [7:0]    Rx_Buffer;
    logic          EMPTY;
    logic          FULL;
    logic [AW:0]   COUNT;
    logic          PKT_OK;
    logic          ERR;
    logic [1:0]    ERR_CODE;
    logic [1:0]    fsm_state;

    logic [7:0]    exp_q[$];
    int            n_cmp;
    int            n_bad;

    pcie_rx_link #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .CONTROL   (CONTROL),
        .DATA      (DATA),
        .VALID_IN  (VALID_IN),
        .RD        (RD),
        .Rx_Buffer (Rx_Buffer),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .COUNT     (COUNT),
        .PKT_OK    (PKT_OK),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE),
        .fsm_state (fsm_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        DATA     = b;
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) tick();
        send(b);
    endtask

    task automatic pop_chk(input string tag);
        check({tag, "_nonempty"}, EMPTY, 1'b0);
        if (exp_q.size() > 0) begin
            check(tag, Rx_Buffer, exp_q.pop_front());
        end else begin
            check({tag, "_queue"}, 0, 1);
        end
        RD = 1'b1;
        tick();
        RD = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) pop_chk(tag);
        check({tag, "_empty"}, EMPTY, 1'b1);
        check({tag, "_count"}, COUNT, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        CONTROL  = 4'b0001;
        DATA     = 8'h00;
        VALID_IN = 1'b0;
        RD       = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset state
        check("rst_empty", EMPTY, 1'b1);
        check("rst_full", FULL, 1'b0);
        check("rst_count", COUNT, 0);
        check("rst_pkt_ok", PKT_OK, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_err_code", ERR_CODE, 2'b00);
        check("rst_state", fsm_state, S_IDLE);

        // 1: good packet 03 A1 B2 C3 D3
        send(8'h03);
        send(8'hA1); exp_q.push_back(8'hA1);
        send(8'hB2); exp_q.push_back(8'hB2);
        check("t1_partial_hidden", EMPTY, 1'b1);
        send(8'hC3); exp_q.push_back(8'hC3);
        check("t1_state_check", fsm_state, S_CHECK);
        send(8'hD3);
        check("t1_pkt_ok", PKT_OK, 1'b1);
        check("t1_err", ERR, 1'b0);
        check("t1_count", COUNT, 3);
        tick();
        check("t1_pkt_ok_pulse", PKT_OK, 1'b0);
        drain("t1_rd", 3);

        // 2: bad checksum
        send(8'h03);
        send(8'hA1); check("t2_empty_a", EMPTY, 1'b1);
        send(8'hB2); check("t2_empty_b", EMPTY, 1'b1);
        send(8'hC3); check("t2_empty_c", EMPTY, 1'b1);
        send(8'h00);
        check("t2_err", ERR, 1'b1);
        check("t2_pkt_ok", PKT_OK, 1'b0);
        check("t2_err_code", ERR_CODE, 2'b01);
        check("t2_count", COUNT, 0);
        check("t2_empty", EMPTY, 1'b1);
        tick();
        check("t2_err_pulse", ERR, 1'b0);
        check("t2_code_held", ERR_CODE, 2'b01);

        // 3: fill to 15, overflow drop, then exact fit to 16
        send(8'h0F);
        for (int i = 0; i < 15; i++) begin
            send(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        send(8'h10);
        check("t3_fill_ok", PKT_OK, 1'b1);
        check("t3_fill_count", COUNT, 15);
        check("t3_fill_full", FULL, 1'b0);
        send(8'h02); send(8'h11); send(8'h22); send(8'h33);
        check("t3_ovf_err", ERR, 1'b1);
        check("t3_ovf_code", ERR_CODE, 2'b10);
        check("t3_ovf_count", COUNT, 15);
        check("t3_ovf_head", Rx_Buffer, 8'h10);
        send(8'h01);
        send(8'h55); exp_q.push_back(8'h55);
        check("t3_full_tentative", FULL, 1'b1);
        check("t3_count_tentative", COUNT, 15);
        send(8'h54);
        check("t3_fit_ok", PKT_OK, 1'b1);
        check("t3_fit_count", COUNT, 16);
        check("t3_fit_full", FULL, 1'b1);
        drain("t3_rd", 16);
        check("t3_full_clear", FULL, 1'b0);

        // 4: 20 packets of length 3 with gaps, concurrent reader
        fork
            begin : writer
                for (int p = 0; p < 20; p++) begin
                    logic [7:0] b0, b1, b2;
                    int wait_cyc;
                    wait_cyc = 0;
                    while (COUNT > 12 && wait_cyc < 300) begin
                        tick();
                        wait_cyc++;
                    end
                    check("t4_space_wait", (wait_cyc < 300), 1'b1);
                    b0 = 8'($urandom_range(0, 255));
                    b1 = 8'($urandom_range(0, 255));
                    b2 = 8'($urandom_range(0, 255));
                    exp_q.push_back(b0);
                    exp_q.push_back(b1);
                    exp_q.push_back(b2);
                    send_gap(8'h03);
                    send_gap(b0);
                    send_gap(b1);
                    send_gap(b2);
                    send_gap(8'h03 ^ b0 ^ b1 ^ b2);
                    check("t4_pkt_ok", PKT_OK, 1'b1);
                    check("t4_no_err", ERR, 1'b0);
                end
            end
            begin : reader
                int popped;
                int budget;
                popped = 0;
                budget = 0;
                while (popped < 60 && budget < 4000) begin
                    if (!EMPTY && $urandom_range(0, 3) != 0) begin
                        if (exp_q.size() > 0) begin
                            check("t4_data", Rx_Buffer, exp_q.pop_front());
                        end else begin
                            check("t4_queue", 0, 1);
                        end
                        RD = 1'b1;
                        popped++;
                    end else begin
                        RD = 1'b0;
                    end
                    tick();
                    budget++;
                end
                RD = 1'b0;
                check("t4_popped", popped, 60);
            end
        join
        check("t4_empty", EMPTY, 1'b1);
        check("t4_count", COUNT, 0);

        // 5a: async reset mid-payload
        send(8'h03); send(8'hA1); send(8'hB2);
        check("t5_mid_state", fsm_state, S_PAYLOAD);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        tick();
        check("t5_rst_state", fsm_state, S_IDLE);
        check("t5_rst_count", COUNT, 0);
        check("t5_rst_pkt_ok", PKT_OK, 1'b0);
        check("t5_rst_err", ERR, 1'b0);
        check("t5_rst_code", ERR_CODE, 2'b00);

        // 5b: flush mid-payload overrides byte and RD, discards committed data
        send(8'h01); send(8'h77); send(8'h76);
        check("t5_pre_count", COUNT, 1);
        send(8'h03); send(8'h11);
        CONTROL  = 4'b0011;
        DATA     = 8'h22;
        VALID_IN = 1'b1;
        RD       = 1'b1;
        tick();
        CONTROL  = 4'b0001;
        VALID_IN = 1'b0;
        RD       = 1'b0;
        exp_q.delete();
        check("t5_fl_state", fsm_state, S_IDLE);
        check("t5_fl_count", COUNT, 0);
        check("t5_fl_empty", EMPTY, 1'b1);
        check("t5_fl_pkt_ok", PKT_OK, 1'b0);
        check("t5_fl_err", ERR, 1'b0);

        // 5c: next packet good, with a disabled-link byte ignored mid-packet
        send(8'h02);
        send(8'h5A); exp_q.push_back(8'h5A);
        CONTROL = 4'b0000;
        send(8'hEE);
        CONTROL = 4'b0001;
        check("t5_hold_state", fsm_state, S_PAYLOAD);
        send(8'hA5); exp_q.push_back(8'hA5);
        send(8'hFD);
        check("t5_next_ok", PKT_OK, 1'b1);
        check("t5_next_count", COUNT, 2);
        drain("t5_rd", 2);

        // 6: pop same cycle as commit, zero-length packets
        send(8'h01); send(8'h44); send(8'h45);
        exp_q.push_back(8'h44);
        check("t6_one_count", COUNT, 1);
        send(8'h02);
        send(8'h66); exp_q.push_back(8'h66);
        send(8'h77); exp_q.push_back(8'h77);
        check("t6_head", Rx_Buffer, exp_q.pop_front());
        RD = 1'b1;
        send(8'h13);
        RD = 1'b0;
        check("t6_pop_commit_ok", PKT_OK, 1'b1);
        check("t6_pop_commit_count", COUNT, 2);
        send(8'h00);
        check("t6_zl_state", fsm_state, S_CHECK);
        send(8'h00);
        check("t6_zl_ok", PKT_OK, 1'b1);
        check("t6_zl_count", COUNT, 2);
        send(8'h00); send(8'h01);
        check("t6_zl_bad_err", ERR, 1'b1);
        check("t6_zl_bad_code", ERR_CODE, 2'b01);
        check("t6_zl_bad_count", COUNT, 2);
        drain("t6_rd", 2);
        RD = 1'b1;
        tick();
        RD = 1'b0;
        check("t6_rd_empty_count", COUNT, 0);
        check("t6_rd_empty_flag", EMPTY, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
